// File: rtl/pic_pkg.sv
// pic_pkg: shared state encoding and constants for the PIC interrupt-acknowledge path.
package pic_pkg;
  typedef enum logic [2:0] {IDLE, ACK1_LOW, ACK1_HIGH, ACK2_LOW, RECOVER} state_t;
  localparam logic [7:0] SPURIOUS_VECTOR_DEFAULT = 8'h07;
  localparam int INTA_PULSES = 2;
endpackage

// File: rtl/pulse_timer.sv
// pulse_timer: loadable down-counter with zero flag, shared by all timed sequencer states.
module pulse_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);
  logic [W-1:0] count;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count <= '0;
    else if (load) count <= load_value;
    else if (count != '0) count <= count - 1'b1;
  assign zero = count == '0;
endmodule

// File: rtl/inta_sequencer.sv
// inta_sequencer: issues the two INTA pulses to the PIC and hands the captured vector to the core.
module inta_sequencer
  import pic_pkg::*;
#(
  parameter int         PULSE_CYCLES    = 2,
  parameter int         GAP_CYCLES      = 2,
  parameter logic [7:0] SPURIOUS_VECTOR = SPURIOUS_VECTOR_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       interrupt,
  input  logic       interrupt_enable,
  input  logic       accept_ready,
  input  logic [7:0] data_bus_in,
  input  logic       data_bus_drive,
  output logic       interrupt_acknowledge_n,
  output logic       busy,
  output logic       vector_valid,
  output logic [7:0] vector,
  output logic       spurious,
  input  logic       vector_taken
);
  localparam int CW = $clog2((PULSE_CYCLES > GAP_CYCLES ? PULSE_CYCLES : GAP_CYCLES) + 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);
  state_t state, next;
  logic int_q, start, zero, load, capture;
  logic [CW-1:0] load_value;
  pulse_timer #(.W(CW)) timer (
    .clk(clk), .reset_n(reset_n), .load(load), .load_value(load_value), .zero(zero)
  );
  always_comb begin
    start = int_q & interrupt_enable & accept_ready & ~vector_valid;
    next = state;
    case (state)
      IDLE:      next = start ? ACK1_LOW : IDLE;
      ACK1_LOW:  next = zero ? ACK1_HIGH : ACK1_LOW;
      ACK1_HIGH: next = zero ? ACK2_LOW : ACK1_HIGH;
      ACK2_LOW:  next = zero ? RECOVER : ACK2_LOW;
      RECOVER:   next = zero ? IDLE : RECOVER;
      default:   next = IDLE;
    endcase
    load = next != state && next != IDLE;
    load_value = (next == ACK1_HIGH || next == RECOVER) ? GAP_LOAD : PULSE_LOAD;
    capture = state == ACK2_LOW && zero;
  end
  // Outputs are registered from next-state so INTA changes exactly on state entry.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      int_q <= 1'b0;
      interrupt_acknowledge_n <= 1'b1;
      busy <= 1'b0;
      vector_valid <= 1'b0;
      vector <= 8'h00;
      spurious <= 1'b0;
    end else begin
      state <= next;
      int_q <= interrupt;
      interrupt_acknowledge_n <= !(next == ACK1_LOW || next == ACK2_LOW);
      busy <= next != IDLE;
      if (capture) begin
        vector <= data_bus_drive ? data_bus_in : SPURIOUS_VECTOR;
        spurious <= !data_bus_drive;
        vector_valid <= 1'b1;
      end else if (vector_taken) vector_valid <= 1'b0;
    end
endmodule

// File: tb/tb_inta_sequencer.sv
// tb_inta_sequencer: directed checks of INTA timing, capture, handshake and reset behaviour.
module tb_inta_sequencer;
  logic clk = 1'b0, reset_n = 1'b0;
  logic interrupt = 1'b1, interrupt_enable = 1'b1, accept_ready = 1'b1;
  logic [7:0] data_bus_in = 8'h4A;
  logic data_bus_drive = 1'b1, vector_taken = 1'b0;
  logic interrupt_acknowledge_n, busy, vector_valid, spurious;
  logic [7:0] vector;
  int n_checks = 0, n_fail = 0;

  inta_sequencer dut (
    .clk(clk), .reset_n(reset_n), .interrupt(interrupt), .interrupt_enable(interrupt_enable),
    .accept_ready(accept_ready), .data_bus_in(data_bus_in), .data_bus_drive(data_bus_drive),
    .interrupt_acknowledge_n(interrupt_acknowledge_n), .busy(busy), .vector_valid(vector_valid),
    .vector(vector), .spurious(spurious), .vector_taken(vector_taken)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called while in cycle 0 (start condition visible); walks cycles 1..9 of the default timeline.
  task automatic run_seq(input string tag, input logic [7:0] exp_vec, input logic exp_sp,
                         input int drop_at, input int take_at);
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == drop_at) interrupt = 1'b0;
      vector_taken = (c == take_at);
      check($sformatf("%s inta c%0d", tag, c), interrupt_acknowledge_n, !(c == 1 || c == 2 || c == 5 || c == 6));
      check($sformatf("%s busy c%0d", tag, c), busy, c <= 8);
      check($sformatf("%s valid c%0d", tag, c), vector_valid, c >= 7);
      if (c == 7) begin
        check({tag, " vector"}, vector, exp_vec);
        check({tag, " spurious"}, spurious, exp_sp);
      end
    end
    vector_taken = 1'b0;
  endtask

  initial begin
    step();
    step();
    check("rst inta", interrupt_acknowledge_n, 1);
    check("rst busy", busy, 0);
    check("rst valid", vector_valid, 0);
    check("rst vector", vector, 8'h00);
    check("rst spurious", spurious, 0);
    reset_n = 1'b1;
    step();
    check("c0 inta", interrupt_acknowledge_n, 1);
    check("c0 busy", busy, 0);
    run_seq("seq1", 8'h4A, 1'b0, 0, 0);
    // vector pending with INT still high: no new acknowledge
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold inta", interrupt_acknowledge_n, 1);
      check("hold busy", busy, 0);
      check("hold valid", vector_valid, 1);
    end
    vector_taken = 1'b1;
    data_bus_drive = 1'b0;
    data_bus_in = 8'hC3;
    step();
    vector_taken = 1'b0;
    check("taken valid", vector_valid, 0);
    check("taken inta", interrupt_acknowledge_n, 1);
    check("taken vector hold", vector, 8'h4A);
    run_seq("spur", 8'h07, 1'b1, 0, 0);
    // interrupts disabled: no sequence despite INT high
    interrupt_enable = 1'b0;
    vector_taken = 1'b1;
    step();
    vector_taken = 1'b0;
    check("clr valid", vector_valid, 0);
    check("clr vector hold", vector, 8'h07);
    check("clr spurious hold", spurious, 1);
    for (int i = 0; i < 20; i++) begin
      step();
      check("dis inta", interrupt_acknowledge_n, 1);
      check("dis busy", busy, 0);
    end
    interrupt_enable = 1'b1;
    data_bus_drive = 1'b1;
    data_bus_in = 8'h5C;
    run_seq("drop", 8'h5C, 1'b0, 3, 6);
    step();
    check("drop idle inta", interrupt_acknowledge_n, 1);
    check("drop idle valid", vector_valid, 1);
    vector_taken = 1'b1;
    step();
    vector_taken = 1'b0;
    interrupt = 1'b1;
    check("drop taken valid", vector_valid, 0);
    step();
    for (int c = 1; c <= 5; c++) step();
    check("pre-rst inta", interrupt_acknowledge_n, 0);
    check("pre-rst vector", vector, 8'h5C);
    #2 reset_n = 1'b0;
    #1;
    check("async inta", interrupt_acknowledge_n, 1);
    check("async busy", busy, 0);
    check("async valid", vector_valid, 0);
    check("async vector", vector, 8'h00);
    interrupt = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post-rst inta", interrupt_acknowledge_n, 1);
      check("post-rst busy", busy, 0);
      check("post-rst valid", vector_valid, 0);
    end
    interrupt = 1'b1;
    data_bus_in = 8'h91;
    step();
    run_seq("restart", 8'h91, 1'b0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
